// File: rtl/decode_uop_sequencer.sv
// decode_uop_sequencer
//   Second-half decode stage. Simple instructions pass straight through to a
//   registered output slice. Microcoded instructions are latched and expanded
//   into a sequence of micro-ops read from an external uop ROM, each merged
//   bitwise with the latched instruction fields under rom_keep.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   flush                 drop the uop in the output slice and any live sequence
//   handle_int            interrupt taken; releases halt
//   halt                  HLT has left this stage; intake stalled
//   s0_valid/s0_ready     input handshake
//   s0_ctrl/pc/...        decoded instruction fields, predictor tag, ROM entry info
//   rom_addr              uop ROM address (upc), registered
//   rom_data/keep/last    uop word, per-bit keep mask, final-uop flag (comb. from rom_addr)
//   s1_valid/s1_ready     output handshake
//   s1_ctrl/pc/...        output uop, parent PC/tag, first/last/index tags
//   seq_overrun           one-cycle pulse when a sequence is cut off at UOP_MAX
module decode_uop_sequencer #(
  parameter int unsigned IADDRW  = 32,
  parameter int unsigned CTRLW   = 96,
  parameter int unsigned ROM_AW  = 7,
  parameter int unsigned UOP_MAX = 16,
  localparam int unsigned UIDXW  = $clog2(UOP_MAX)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              handle_int,
  output logic              halt,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [CTRLW-1:0]  s0_ctrl,
  input  logic [IADDRW-1:0] s0_pc,
  input  logic              s0_branch_taken,
  input  logic              s0_rom_start,
  input  logic [ROM_AW-1:0] s0_rom_addr,
  input  logic              s0_is_hlt,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [CTRLW-1:0]  rom_data,
  input  logic [CTRLW-1:0]  rom_keep,
  input  logic              rom_last,
  output logic              s1_valid,
  input  logic              s1_ready,
  output logic [CTRLW-1:0]  s1_ctrl,
  output logic [IADDRW-1:0] s1_pc,
  output logic              s1_branch_taken,
  output logic              s1_uop_first,
  output logic              s1_uop_last,
  output logic [UIDXW-1:0]  s1_uop_idx,
  output logic              seq_overrun
);

  localparam logic [UIDXW-1:0] IDX_LAST = UIDXW'(UOP_MAX - 1);

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_SEQ  = 1'b1
  } state_t;

  state_t              state, state_n;
  logic [CTRLW-1:0]    lat_ctrl, lat_ctrl_n;
  logic [IADDRW-1:0]   lat_pc, lat_pc_n;
  logic                lat_bt, lat_bt_n;
  logic [ROM_AW-1:0]   upc, upc_n;
  logic [UIDXW-1:0]    idx, idx_n;
  logic                halt_n;
  logic                s1_valid_n;
  logic [CTRLW-1:0]    s1_ctrl_n;
  logic [IADDRW-1:0]   s1_pc_n;
  logic                s1_branch_taken_n;
  logic                s1_uop_first_n;
  logic                s1_uop_last_n;
  logic [UIDXW-1:0]    s1_uop_idx_n;
  logic                seq_overrun_n;

  logic                out_free;
  logic                accept;
  logic                seq_last;

  // Output slice may load when empty or being drained this cycle.
  assign out_free = !s1_valid || s1_ready;
  assign s0_ready = (state == ST_PASS) && out_free && !halt && !flush && !reset;
  assign accept   = s0_valid && s0_ready;
  assign rom_addr = upc;
  // A sequence ends on the ROM's own marker or is forced to end at UOP_MAX.
  assign seq_last = rom_last || (idx == IDX_LAST);

  // State and output-slice registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_PASS;
      lat_ctrl        <= '0;
      lat_pc          <= '0;
      lat_bt          <= 1'b0;
      upc             <= '0;
      idx             <= '0;
      halt            <= 1'b0;
      s1_valid        <= 1'b0;
      s1_ctrl         <= '0;
      s1_pc           <= '0;
      s1_branch_taken <= 1'b0;
      s1_uop_first    <= 1'b0;
      s1_uop_last     <= 1'b0;
      s1_uop_idx      <= '0;
      seq_overrun     <= 1'b0;
    end else begin
      state           <= state_n;
      lat_ctrl        <= lat_ctrl_n;
      lat_pc          <= lat_pc_n;
      lat_bt          <= lat_bt_n;
      upc             <= upc_n;
      idx             <= idx_n;
      halt            <= halt_n;
      s1_valid        <= s1_valid_n;
      s1_ctrl         <= s1_ctrl_n;
      s1_pc           <= s1_pc_n;
      s1_branch_taken <= s1_branch_taken_n;
      s1_uop_first    <= s1_uop_first_n;
      s1_uop_last     <= s1_uop_last_n;
      s1_uop_idx      <= s1_uop_idx_n;
      seq_overrun     <= seq_overrun_n;
    end
  end

  // Next-state and output-slice logic.
  always_comb begin
    state_n           = state;
    lat_ctrl_n        = lat_ctrl;
    lat_pc_n          = lat_pc;
    lat_bt_n          = lat_bt;
    upc_n             = upc;
    idx_n             = idx;
    halt_n            = halt;
    s1_valid_n        = s1_valid;
    s1_ctrl_n         = s1_ctrl;
    s1_pc_n           = s1_pc;
    s1_branch_taken_n = s1_branch_taken;
    s1_uop_first_n    = s1_uop_first;
    s1_uop_last_n     = s1_uop_last;
    s1_uop_idx_n      = s1_uop_idx;
    seq_overrun_n     = 1'b0;

    // Halt is independent of flush; it can only be set by an accepted HLT,
    // which is impossible while already halted.
    if (accept && s0_is_hlt) begin
      halt_n = 1'b1;
    end else if (handle_int) begin
      halt_n = 1'b0;
    end

    if (flush) begin
      s1_valid_n = 1'b0;
      state_n    = ST_PASS;
      idx_n      = '0;
    end else begin
      case (state)
        ST_PASS: begin
          if (out_free) begin
            s1_valid_n = 1'b0;
            if (accept && s0_rom_start) begin
              lat_ctrl_n = s0_ctrl;
              lat_pc_n   = s0_pc;
              lat_bt_n   = s0_branch_taken;
              upc_n      = s0_rom_addr;
              idx_n      = '0;
              state_n    = ST_SEQ;
            end else if (accept) begin
              s1_valid_n        = 1'b1;
              s1_ctrl_n         = s0_ctrl;
              s1_pc_n           = s0_pc;
              s1_branch_taken_n = s0_branch_taken;
              s1_uop_first_n    = 1'b1;
              s1_uop_last_n     = 1'b1;
              s1_uop_idx_n      = '0;
            end
          end
        end
        ST_SEQ: begin
          if (out_free) begin
            s1_valid_n        = 1'b1;
            s1_ctrl_n         = (lat_ctrl & rom_keep) | (rom_data & ~rom_keep);
            s1_pc_n           = lat_pc;
            s1_branch_taken_n = lat_bt;
            s1_uop_first_n    = (idx == '0);
            s1_uop_last_n     = seq_last;
            s1_uop_idx_n      = idx;
            upc_n             = upc + ROM_AW'(1);
            idx_n             = idx + UIDXW'(1);
            seq_overrun_n     = (idx == IDX_LAST) && !rom_last;
            if (seq_last) begin
              state_n = ST_PASS;
              idx_n   = '0;
            end
          end
        end
        default: state_n = ST_PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_uop_sequencer.sv
// Bench for decode_uop_sequencer: directed scenarios with literal expectations,
// then random traffic, all watched by a queue-based model of the uop stream.
module tb_decode_uop_sequencer;
  localparam int unsigned IADDRW  = 32;
  localparam int unsigned CTRLW   = 96;
  localparam int unsigned ROM_AW  = 7;
  localparam int unsigned UOP_MAX = 16;
  localparam int unsigned UIDXW   = 4;
  localparam int unsigned DEPTH   = 1 << ROM_AW;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              flush = 1'b0, handle_int = 1'b0, halt;
  logic              s0_valid = 1'b0, s0_ready;
  logic [CTRLW-1:0]  s0_ctrl = '0;
  logic [IADDRW-1:0] s0_pc = '0;
  logic              s0_branch_taken = 1'b0, s0_rom_start = 1'b0, s0_is_hlt = 1'b0;
  logic [ROM_AW-1:0] s0_rom_addr = '0;
  logic [ROM_AW-1:0] rom_addr;
  logic [CTRLW-1:0]  rom_data, rom_keep;
  logic              rom_last;
  logic              s1_valid, s1_ready = 1'b1;
  logic [CTRLW-1:0]  s1_ctrl;
  logic [IADDRW-1:0] s1_pc;
  logic              s1_branch_taken, s1_uop_first, s1_uop_last, seq_overrun;
  logic [UIDXW-1:0]  s1_uop_idx;

  logic [CTRLW-1:0]  rom_mem  [DEPTH];
  logic [CTRLW-1:0]  keep_mem [DEPTH];
  logic              last_mem [DEPTH];

  assign rom_data = rom_mem[rom_addr];
  assign rom_keep = keep_mem[rom_addr];
  assign rom_last = last_mem[rom_addr];

  always #5 clk = ~clk;

  decode_uop_sequencer dut (
    .clk(clk), .reset(reset), .flush(flush), .handle_int(handle_int), .halt(halt),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_ctrl(s0_ctrl), .s0_pc(s0_pc),
    .s0_branch_taken(s0_branch_taken), .s0_rom_start(s0_rom_start),
    .s0_rom_addr(s0_rom_addr), .s0_is_hlt(s0_is_hlt),
    .rom_addr(rom_addr), .rom_data(rom_data), .rom_keep(rom_keep), .rom_last(rom_last),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_ctrl(s1_ctrl), .s1_pc(s1_pc),
    .s1_branch_taken(s1_branch_taken), .s1_uop_first(s1_uop_first),
    .s1_uop_last(s1_uop_last), .s1_uop_idx(s1_uop_idx), .seq_overrun(seq_overrun)
  );

  typedef struct packed {
    logic [CTRLW-1:0]  ctrl;
    logic [IADDRW-1:0] pc;
    logic              bt;
    logic              first;
    logic              last;
    logic [UIDXW-1:0]  idx;
    logic              trunc;
  } uop_t;

  int   n_chk  = 0;
  int   n_pass = 0;
  uop_t pend[$];          // uops owed by the DUT but not yet shown on s1
  uop_t shown;            // uop currently shown on s1
  logic shown_v = 1'b0;
  logic halt_m  = 1'b0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  function automatic logic [191:0] pack(input uop_t u);
    return 192'({u.ctrl, u.pc, u.bt, u.first, u.last, u.idx});
  endfunction

  function automatic logic [CTRLW-1:0] rnd96();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Everything a microcoded instruction must produce, from its entry point.
  function automatic void expand(input logic [CTRLW-1:0] c, input logic [IADDRW-1:0] pc,
                                 input logic bt, input logic [ROM_AW-1:0] entry);
    for (int i = 0; i < int'(UOP_MAX); i++) begin
      int   a;
      uop_t u;
      a       = (int'(entry) + i) % int'(DEPTH);
      u.ctrl  = (c & keep_mem[a]) | (rom_mem[a] & ~keep_mem[a]);
      u.pc    = pc;
      u.bt    = bt;
      u.first = (i == 0);
      u.last  = last_mem[a] || (i == int'(UOP_MAX) - 1);
      u.trunc = (i == int'(UOP_MAX) - 1) && !last_mem[a];
      u.idx   = UIDXW'(i);
      pend.push_back(u);
      if (u.last) break;
    end
  endfunction

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    uop_t got;
    uop_t p;
    logic exp_ready;
    if (reset) begin
      pend.delete();
      shown_v = 1'b0;
      halt_m  = 1'b0;
    end else begin
      got.ctrl = s1_ctrl; got.pc = s1_pc; got.bt = s1_branch_taken;
      got.first = s1_uop_first; got.last = s1_uop_last; got.idx = s1_uop_idx; got.trunc = 1'b0;
      if (s1_valid && !shown_v) begin
        if (pend.size() == 0) begin
          n_chk++;
          $display("FAIL uop_extra: got pc %0h idx %0d expected no uop (t=%0t)", s1_pc, s1_uop_idx, $time);
        end else begin
          shown   = pend.pop_front();
          shown_v = 1'b1;
          chk("uop", pack(got), pack(shown));
          chk("overrun_pulse", 192'(seq_overrun), 192'(shown.trunc));
        end
      end else if (s1_valid) begin
        chk("stall_hold", {pack(got), 192'(seq_overrun)} , {pack(shown), 192'(0)});
      end else begin
        chk("overrun_idle", 192'(seq_overrun), 192'(0));
      end
      chk("halt", 192'(halt), 192'(halt_m));
      exp_ready = !halt_m && !flush && (pend.size() == 0) && (!s1_valid || s1_ready);
      chk("s0_ready", 192'(s0_ready), 192'(exp_ready));

      if (flush) begin
        pend.delete();
        shown_v = 1'b0;
      end else if (s1_valid && s1_ready) begin
        shown_v = 1'b0;
      end
      if (s0_valid && s0_ready) begin
        if (s0_rom_start) begin
          expand(s0_ctrl, s0_pc, s0_branch_taken, s0_rom_addr);
        end else begin
          p.ctrl = s0_ctrl; p.pc = s0_pc; p.bt = s0_branch_taken;
          p.first = 1'b1; p.last = 1'b1; p.idx = '0; p.trunc = 1'b0;
          pend.push_back(p);
        end
      end
      if (s0_valid && s0_ready && s0_is_hlt) halt_m = 1'b1;
      else if (handle_int) halt_m = 1'b0;
    end
  end

  logic [UIDXW-1:0]  c_idx [32];
  logic              c_first [32], c_last [32], c_rdy [32];
  logic [ROM_AW-1:0] c_ra [32];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rom, input logic [ROM_AW-1:0] entry, input logic hlt,
                       input logic [IADDRW-1:0] pc);
    bit ok = 0;
    s0_valid = 1'b1; s0_rom_start = rom; s0_rom_addr = entry; s0_is_hlt = hlt;
    s0_pc = pc; s0_ctrl = rnd96(); s0_branch_taken = 1'($urandom);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s0_ready) begin ok = 1; break; end
    end
    if (!ok) fail_now("issue_accept");
    tick();
    s0_valid = 1'b0; s0_is_hlt = 1'b0; s0_rom_start = 1'b0;
  endtask

  // Record each handshaken uop until the last one; ready optionally toggles 1,0,0,1.
  task automatic collect(input bit toggle, input int budget, output int n, output int ov);
    logic [3:0] pat;
    bit done;
    pat = 4'b1001;
    n = 0; ov = 0; done = 0;
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      s1_ready = toggle ? pat[cyc % 4] : 1'b1;
      @(negedge clk);
      if (seq_overrun) ov++;
      if (s1_valid && s1_ready && n < 32) begin
        c_idx[n] = s1_uop_idx; c_first[n] = s1_uop_first; c_last[n] = s1_uop_last;
        c_ra[n] = rom_addr; c_rdy[n] = s0_ready;
        n++;
        if (s1_uop_last) done = 1;
      end
      tick();
    end
    if (!done) fail_now("collect_last");
    s1_ready = 1'b1;
  endtask

  initial begin
    int n, ov;
    bit ok;
    for (int i = 0; i < int'(DEPTH); i++) begin
      rom_mem[i] = rnd96(); keep_mem[i] = rnd96(); last_mem[i] = ($urandom_range(0, 3) == 0);
    end
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_s1_valid", 192'(s1_valid), 192'(0));
    chk("rst_halt", 192'(halt), 192'(0));
    chk("rst_rom_addr", 192'(rom_addr), 192'(0));
    chk("rst_overrun", 192'(seq_overrun), 192'(0));
    chk("rst_s0_ready", 192'(s0_ready), 192'(1));
    tick();

    // Four back-to-back pass-through instructions
    for (int k = 0; k <= 4; k++) begin
      s0_valid = (k < 4); s0_pc = IADDRW'(32'h1000 + 4 * k); s0_ctrl = rnd96();
      @(negedge clk);
      if (k < 4) chk("b2b_ready", 192'(s0_ready), 192'(1));
      if (k > 0) begin
        chk("b2b_valid", 192'(s1_valid), 192'(1));
        chk("b2b_pc", 192'(s1_pc), 192'(32'h1000 + 4 * (k - 1)));
        chk("b2b_tags", 192'({s1_uop_first, s1_uop_last, s1_uop_idx}), 192'(6'b11_0000));
      end
      tick();
    end
    s0_valid = 1'b0;

    // Microcoded instruction at 0x10, three uops
    last_mem[8'h10] = 1'b0; last_mem[8'h11] = 1'b0; last_mem[8'h12] = 1'b1;
    issue(1'b1, 7'h10, 1'b0, 32'h2000);
    collect(1'b0, 20, n, ov);
    chk("rom3_count", 192'(n), 192'(3));
    for (int i = 0; i < 3; i++) begin
      chk("rom3_idx", 192'(c_idx[i]), 192'(i));
      chk("rom3_first", 192'(c_first[i]), 192'(i == 0));
      chk("rom3_last", 192'(c_last[i]), 192'(i == 2));
      chk("rom3_addr", 192'(c_ra[i]), 192'(8'h11 + i));
    end
    chk("rom3_busy0", 192'(c_rdy[0]), 192'(0));
    chk("rom3_busy1", 192'(c_rdy[1]), 192'(0));

    // Same instruction under a stalling consumer
    issue(1'b1, 7'h10, 1'b0, 32'h2010);
    collect(1'b1, 40, n, ov);
    chk("stall_count", 192'(n), 192'(3));
    chk("stall_idx_last", 192'(c_idx[2]), 192'(2));

    // Entry 0x7F wraps; no ROM end marker for 16 words -> truncation
    last_mem[8'h7F] = 1'b0;
    for (int i = 0; i < 15; i++) last_mem[i] = 1'b0;
    issue(1'b1, 7'h7F, 1'b0, 32'h3000);
    collect(1'b0, 40, n, ov);
    chk("ovr_count", 192'(n), 192'(16));
    chk("ovr_wrap_addr", 192'(c_ra[0]), 192'(0));
    chk("ovr_idx15", 192'(c_idx[15]), 192'(15));
    chk("ovr_last15", 192'(c_last[15]), 192'(1));
    chk("ovr_last14", 192'(c_last[14]), 192'(0));
    chk("ovr_pulse", 192'(ov), 192'(1));

    // Flush while idx 1 is on the output
    issue(1'b1, 7'h10, 1'b0, 32'h4000);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s1_valid && s1_uop_idx == 0) begin ok = 1; break; end
    end
    if (!ok) fail_now("flush_wait_idx0");
    tick(); flush = 1'b1;
    @(negedge clk);
    chk("flush_at_idx1", 192'({s1_valid, s1_uop_idx}), 192'(5'b1_0001));
    tick(); flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", 192'(s1_valid), 192'(0));
    chk("flush_pass", 192'(s0_ready), 192'(1));
    tick();
    issue(1'b0, 7'h00, 1'b0, 32'h4100);
    @(negedge clk);
    chk("post_flush_uop", 192'({s1_valid, s1_pc, s1_uop_first, s1_uop_last}), 192'({1'b1, 32'h4100, 2'b11}));
    tick();

    // HLT stalls intake until an interrupt is taken
    issue(1'b0, 7'h00, 1'b1, 32'h5000);
    s0_valid = 1'b1; s0_pc = 32'h5004;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("halt_set", 192'({halt, s0_ready}), 192'(2'b10));
      tick();
    end
    handle_int = 1'b1;
    tick(); handle_int = 1'b0;
    @(negedge clk);
    chk("halt_clear", 192'({halt, s0_ready}), 192'(2'b01));
    tick(); s0_valid = 1'b0;

    // Asynchronous reset in the middle of a sequence
    issue(1'b1, 7'h7F, 1'b0, 32'h6000);
    repeat (4) tick();
    #1 reset = 1'b1;
    #1 chk("arst_now", 192'({s1_valid, rom_addr, s0_ready}), 192'(0));
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("arst_after", 192'({s1_valid, rom_addr}), 192'(0));
    tick();

    // Random traffic against the model
    for (int i = 0; i < int'(DEPTH); i++) last_mem[i] = ($urandom_range(0, 4) == 0);
    for (int c = 0; c < 3000; c++) begin
      s0_valid = ($urandom_range(0, 2) != 0);
      s0_ctrl = rnd96(); s0_pc = $urandom; s0_branch_taken = 1'($urandom);
      s0_rom_start = ($urandom_range(0, 3) == 0);
      s0_rom_addr = ROM_AW'($urandom);
      s0_is_hlt = !s0_rom_start && ($urandom_range(0, 39) == 0);
      s1_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 29) == 0);
      handle_int = ($urandom_range(0, 9) == 0);
      tick();
    end
    s0_valid = 1'b0; flush = 1'b0; s1_ready = 1'b1; s0_is_hlt = 1'b0; handle_int = 1'b0;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (pend.size() == 0 && !shown_v) begin ok = 1; break; end
    end
    if (!ok) fail_now("drain");
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
